// File: rtl/jpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jpu (package)
//  Brief    : Shared types and register map for the JPU timer array.
//  Revision : 1.0 - initial multi-channel timer release
// ============================================================================
package jpu;

    // Per-channel control register layout, bit 2 down to bit 0
    typedef struct packed {
        logic irq_en;
        logic periodic;
        logic en;
    } timer_ctrl_s;

    // Word offsets inside one channel's register window
    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PERIOD = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_STATUS = 2'd3;

endpackage
`default_nettype wire

// File: rtl/jpu_timer_chan.sv
`default_nettype none
// ============================================================================
//  Module   : jpu_timer_chan
//  Brief    : One down-counting timer channel: ctrl, period, count, sticky
//             pending flag and the idle/run reload state machine.
//  Revision : 1.0 - initial multi-channel timer release
// ============================================================================
module jpu_timer_chan
    import jpu::*;
#(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] RST_PER = WIDTH'(100)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_we_ctrl,
    input  logic             i_we_period,
    input  logic             i_w1c,
    input  timer_ctrl_s      i_ctrl,
    input  logic [WIDTH-1:0] i_period,
    output timer_ctrl_s      o_ctrl,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_count,
    output logic             o_pending
);

    // The run state doubles as the CTRL.en bit
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic             r_irq_en;
    logic             r_periodic;
    logic             r_pending;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             w_expire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and count: a CTRL write pre-empts a tick in the same cycle
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_expire     = 1'b0;
        if (i_we_ctrl) begin
            w_state_next = i_ctrl.en ? ST_RUN : ST_IDLE;
            if (i_ctrl.en && (r_state == ST_IDLE)) begin
                w_count_next = r_period;
            end
        end else if (i_we_period && (r_state == ST_IDLE)) begin
            w_count_next = i_period;
        end else if (i_tick && (r_state == ST_RUN)) begin
            if (r_count != '0) begin
                w_count_next = r_count - WIDTH'(1);
            end else begin
                w_expire = 1'b1;
                if (r_periodic) begin
                    w_count_next = r_period;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
        end
    end

    // Count, period and control bits; a running channel's new period waits for reload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_period   <= RST_PER;
            r_irq_en   <= 1'b0;
            r_periodic <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (i_we_period) begin
                r_period <= i_period;
            end
            if (i_we_ctrl) begin
                r_irq_en   <= i_ctrl.irq_en;
                r_periodic <= i_ctrl.periodic;
            end
        end
    end

    // Sticky pending flag; an expiry beats a simultaneous write-one-to-clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_expire) begin
            r_pending <= 1'b1;
        end else if (i_w1c) begin
            r_pending <= 1'b0;
        end
    end

    assign o_ctrl    = {r_irq_en, r_periodic, (r_state == ST_RUN)};
    assign o_period  = r_period;
    assign o_count   = r_count;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/jpu_timer_array.sv
`default_nettype none
// ============================================================================
//  Module   : jpu_timer_array
//  Brief    : NCH-channel prescaled down-counting timer on the CPU register
//             bus with one combined, registered interrupt output.
//  Revision : 1.0 - initial multi-channel timer release
// ============================================================================
module jpu_timer_array
    import jpu::*;
#(
    parameter int               NCH     = 4,
    parameter int               WIDTH   = 16,
    parameter int               PRESC_W = 8,
    parameter logic [WIDTH-1:0] RST_PER = WIDTH'(100)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(NCH)+1:0]   addr,
    input  logic [31:0]              wdata,
    input  logic                     we,
    input  logic                     re,
    output logic [31:0]              rdata,
    input  logic [PRESC_W-1:0]       prescale,
    output logic                     irq
);

    logic [PRESC_W-1:0] r_presc;
    logic               w_tick;
    logic [4:0]         w_ch;
    logic [1:0]         w_reg;
    logic               w_ch_valid;
    logic [NCH-1:0]     w_sel;
    logic [NCH-1:0]     w_pending;
    logic [NCH-1:0]     w_irq_en;
    timer_ctrl_s        w_ctrl   [NCH];
    logic [WIDTH-1:0]   w_period [NCH];
    logic [WIDTH-1:0]   w_count  [NCH];
    logic [31:0]        w_rd_data;
    logic [31:0]        r_rdata;
    logic               r_irq;
    logic               w_unused;

    // The >= compare lets a lowered prescale wrap instead of running to overflow
    assign w_tick = (r_presc >= prescale);

    // Free-running prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Address split: shifting avoids an empty channel field when NCH is 1
    assign w_ch       = 5'(addr >> 2);
    assign w_reg      = addr[1:0];
    assign w_ch_valid = (int'(w_ch) < NCH);
    assign w_unused   = &{1'b0, wdata};

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_chan
            assign w_sel[i]    = w_ch_valid && (w_ch == 5'(i));
            assign w_irq_en[i] = w_ctrl[i].irq_en;

            jpu_timer_chan #(
                .WIDTH   (WIDTH),
                .RST_PER (RST_PER)
            ) u_chan (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_tick      (w_tick),
                .i_we_ctrl   (we && w_sel[i] && (w_reg == TMR_CTRL)),
                .i_we_period (we && w_sel[i] && (w_reg == TMR_PERIOD)),
                .i_w1c       (we && w_sel[i] && (w_reg == TMR_STATUS) && wdata[0]),
                .i_ctrl      (timer_ctrl_s'(wdata[2:0])),
                .i_period    (wdata[WIDTH-1:0]),
                .o_ctrl      (w_ctrl[i]),
                .o_period    (w_period[i]),
                .o_count     (w_count[i]),
                .o_pending   (w_pending[i])
            );
        end
    endgenerate

    // Read mux; out-of-range channels fall through to zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_ch_valid && (int'(w_ch) == i)) begin
                case (w_reg)
                    TMR_CTRL:   w_rd_data = 32'(w_ctrl[i]);
                    TMR_PERIOD: w_rd_data = 32'(w_period[i]);
                    TMR_COUNT:  w_rd_data = 32'(w_count[i]);
                    TMR_STATUS: w_rd_data = 32'(w_pending[i]);
                endcase
            end
        end
    end

    // Registered read data and interrupt; reads capture the pre-write state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (re) begin
                r_rdata <= w_rd_data;
            end
            r_irq <= |(w_pending & w_irq_en);
        end
    end

    assign rdata = r_rdata;
    assign irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_jpu_timer_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jpu_timer_array
//  Brief    : Scoreboard bench for jpu_timer_array: directed register-bus
//             stimulus with hand-derived expectations, decoupled monitor.
//  Revision : 1.0 - initial multi-channel timer release
// ============================================================================
module tb_jpu_timer_array;
    import jpu::*;

    localparam int NCH     = 4;
    localparam int WIDTH   = 16;
    localparam int PRESC_W = 8;
    localparam int AW      = $clog2(NCH) + 2;

    logic               clk;
    logic               rst_n;
    logic [AW-1:0]      addr;
    logic [31:0]        wdata;
    logic               we;
    logic               re;
    logic [31:0]        rdata;
    logic [PRESC_W-1:0] prescale;
    logic               irq;

    typedef struct {
        string       nm;
        logic [31:0] val;
    } exp_t;

    exp_t rq[$];
    exp_t iq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic irq_probe = 1'b0;
    logic re_q = 1'b0;

    jpu_timer_array #(
        .NCH     (NCH),
        .WIDTH   (WIDTH),
        .PRESC_W (PRESC_W),
        .RST_PER (16'd100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .rdata    (rdata),
        .prescale (prescale),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data is presented the cycle after the strobe was sampled
    always @(posedge clk) re_q <= re;

    // Monitor: pop and compare whenever the DUT presents read data or irq is probed
    always @(negedge clk) begin : mon
        exp_t e;
        if (re_q) begin
            n_tests++;
            if (rq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: rdata=0x%0h with no expectation queued", rdata);
            end else begin
                e = rq.pop_front();
                if (rdata !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: rdata=0x%0h required 0x%0h", e.nm, rdata, e.val);
                end
            end
        end
        if (irq_probe) begin
            n_tests++;
            if (iq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_irq_probe: irq=%0b with no expectation queued", irq);
            end else begin
                e = iq.pop_front();
                if (irq !== e.val[0]) begin
                    n_fail++;
                    $display("FAIL %s: irq=%0b required %0b", e.nm, irq, e.val[0]);
                end
            end
        end
    end

    // Asynchronous reset must clear outputs without waiting for a clock
    always @(negedge rst_n) begin
        #1;
        n_tests++;
        if ((irq !== 1'b0) || (rdata !== 32'd0)) begin
            n_fail++;
            $display("FAIL async_reset: irq=%0b rdata=0x%0h required irq=0 rdata=0x0", irq, rdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int ch, input logic [1:0] r, input logic [31:0] d);
        addr  = {2'(ch), r};
        wdata = d;
        we    = 1'b1;
        step();
        we    = 1'b0;
    endtask

    task automatic rd(input int ch, input logic [1:0] r, input logic [31:0] exp, input string nm);
        rq.push_back('{nm, exp});
        addr = {2'(ch), r};
        re   = 1'b1;
        step();
        re   = 1'b0;
    endtask

    task automatic rdwr(input int ch, input logic [1:0] r, input logic [31:0] d,
                        input logic [31:0] exp, input string nm);
        rq.push_back('{nm, exp});
        addr  = {2'(ch), r};
        wdata = d;
        we    = 1'b1;
        re    = 1'b1;
        step();
        we    = 1'b0;
        re    = 1'b0;
    endtask

    task automatic chk_irq(input logic e, input string nm);
        iq.push_back('{nm, {31'd0, e}});
        irq_probe = 1'b1;
        step();
        irq_probe = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        addr     = '0;
        wdata    = '0;
        we       = 1'b0;
        re       = 1'b0;
        prescale = '0;
        idle(3);
        rst_n = 1'b1;

        // Reset values
        for (int c = 0; c < NCH; c++) rd(c, TMR_PERIOD, 32'd100, "rst_period");
        rd(0, TMR_CTRL,   32'd0, "rst_ctrl");
        rd(0, TMR_COUNT,  32'd0, "rst_count");
        rd(0, TMR_STATUS, 32'd0, "rst_status");
        chk_irq(1'b0, "rst_irq");

        // Periodic ch0, period 3: expiry every 4 ticks, W1C race on the third
        wr(0, TMR_PERIOD, 32'd3);
        wr(0, TMR_CTRL,   32'd7);
        rd(0, TMR_COUNT, 32'd3, "per_count3");
        rd(0, TMR_COUNT, 32'd2, "per_count2");
        rd(0, TMR_COUNT, 32'd1, "per_count1");
        rd(0, TMR_COUNT, 32'd0, "per_count0");
        chk_irq(1'b0, "per_irq_latency");
        rd(0, TMR_STATUS, 32'd1, "per_pending1");
        chk_irq(1'b1, "per_irq_high");
        rd(0, TMR_COUNT, 32'd0, "per_count0b");
        rd(0, TMR_COUNT, 32'd3, "per_reload");
        wr(0, TMR_STATUS, 32'd1);
        rd(0, TMR_STATUS, 32'd0, "per_w1c_clear");
        wr(0, TMR_STATUS, 32'd1);
        rd(0, TMR_STATUS, 32'd1, "w1c_race_set_wins");
        wr(0, TMR_CTRL,   32'd0);
        wr(0, TMR_STATUS, 32'd1);

        // One-shot ch1, period 5: expiry after 6 ticks, then stops
        wr(1, TMR_PERIOD, 32'd5);
        wr(1, TMR_CTRL,   32'd5);
        idle(5);
        rd(1, TMR_STATUS, 32'd0, "os_not_yet");
        rd(1, TMR_STATUS, 32'd1, "os_pending");
        rd(1, TMR_CTRL,   32'd4, "os_en_cleared");
        rd(1, TMR_COUNT,  32'd0, "os_count0");
        chk_irq(1'b1, "os_irq");
        wr(1, TMR_STATUS, 32'd1);
        idle(8);
        rd(1, TMR_STATUS, 32'd0, "os_no_refire");
        rd(1, TMR_COUNT,  32'd0, "os_count_held");
        chk_irq(1'b0, "os_irq_low");

        // Prescaler 9, ch2 period 0 periodic: expiry every 10 clocks
        prescale = 8'd9;
        wr(2, TMR_PERIOD, 32'd0);
        wr(2, TMR_CTRL,   32'd3);
        idle(7);
        rd(2, TMR_STATUS, 32'd0, "psc_before1");
        rd(2, TMR_STATUS, 32'd1, "psc_fire1");
        wr(2, TMR_STATUS, 32'd1);
        idle(7);
        rd(2, TMR_STATUS, 32'd0, "psc_before2");
        rd(2, TMR_STATUS, 32'd1, "psc_fire2");
        wr(2, TMR_CTRL,   32'd0);
        wr(2, TMR_STATUS, 32'd1);
        prescale = 8'd0;

        // Multi-channel irq masking: ch1 expires without irq_en
        wr(1, TMR_PERIOD, 32'd1);
        wr(1, TMR_CTRL,   32'd3);
        wr(0, TMR_PERIOD, 32'd2);
        wr(0, TMR_CTRL,   32'd5);
        rd(1, TMR_STATUS, 32'd1, "mc_ch1_pending");
        chk_irq(1'b0, "mc_ch1_masked_a");
        chk_irq(1'b0, "mc_ch1_masked_b");
        chk_irq(1'b0, "mc_ch0_not_yet");
        chk_irq(1'b1, "mc_ch0_irq");
        wr(3, TMR_PERIOD, 32'd0);
        wr(3, TMR_CTRL,   32'd5);
        wr(0, TMR_STATUS, 32'd1);
        rd(3, TMR_STATUS, 32'd1, "mc_ch3_pending");
        chk_irq(1'b1, "mc_ch3_irq");
        wr(3, TMR_STATUS, 32'd1);
        chk_irq(1'b1, "mc_irq_lag");
        chk_irq(1'b0, "mc_irq_dropped");
        rd(1, TMR_STATUS, 32'd1, "mc_ch1_still_pending");

        // COUNT is read-only; simultaneous read/write returns the old value
        wr(0, TMR_COUNT, 32'd55);
        rd(0, TMR_COUNT, 32'd0, "count_ro");
        rdwr(1, TMR_PERIOD, 32'd7, 32'd1, "rdwr_prewrite");
        rd(1, TMR_PERIOD, 32'd7, "rdwr_written");

        // Asynchronous reset mid-count with an interrupt asserted
        wr(1, TMR_CTRL, 32'd7);
        idle(1);
        chk_irq(1'b1, "pre_reset_irq");
        #2;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rd(1, TMR_CTRL,   32'd0,   "post_rst_ctrl");
        rd(1, TMR_PERIOD, 32'd100, "post_rst_period1");
        rd(0, TMR_PERIOD, 32'd100, "post_rst_period0");
        rd(1, TMR_COUNT,  32'd0,   "post_rst_count");
        rd(1, TMR_STATUS, 32'd0,   "post_rst_status");
        chk_irq(1'b0, "post_rst_irq");

        idle(2);
        n_tests++;
        if ((rq.size() != 0) || (iq.size() != 0)) begin
            n_fail++;
            $display("FAIL drain: %0d reads and %0d irq probes outstanding, required 0 and 0",
                     rq.size(), iq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
